// File: rtl/add_arbiter_pkg.sv
// Shared types and default sizing for the add_arbiter block.
package add_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

endpackage : add_arbiter_pkg

// File: rtl/add_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts just after the last
// granted index and wraps modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Scan from farthest to nearest so the nearest valid index after last wins.
  always_comb begin
    logic [IW-1:0] idx_v;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx_v   = '0;
    for (int k = N; k >= 1; k--) begin
      idx_v = IW'((int'(last) + k) % N);
      if (en && req[idx_v]) begin
        gnt        = '0;
        gnt[idx_v] = 1'b1;
        gnt_idx    = idx_v;
        any        = 1'b1;
      end else begin
        gnt = gnt;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/add_arbiter.sv
// One registered adder shared round-robin among NREQ valid/ready requesters,
// with a single ID-tagged response register that honours backpressure.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
  output logic [NREQ-1:0]             req_ready,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic                        rsp_carry,
  input  logic                        rsp_ready
);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]  gnt_s;
  logic [ID_W-1:0]  gnt_idx_s;
  logic             any_s;
  logic             can_issue_s;
  logic             grant_en_s;
  logic [WIDTH:0]   sum_full_s;

  // The response slot frees up either when empty or when drained this cycle;
  // rst_n gating keeps the grant low while reset is held.
  assign can_issue_s = (state_q == IDLE) || rsp_ready;
  assign grant_en_s  = rst_n && can_issue_s;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .last    (last_q),
    .en      (grant_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (any_s)
  );

  assign sum_full_s = {1'b0, req_a[gnt_idx_s]} + {1'b0, req_b[gnt_idx_s]};

  // Next-state and response-register update.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_valid_d = rsp_valid_q;
    if (any_s) begin
      state_d     = FULL;
      last_d      = gnt_idx_s;
      rsp_id_d    = gnt_idx_s;
      {rsp_carry_d, rsp_sum_d} = sum_full_s;
      rsp_valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
        FULL: begin
          if (rsp_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
          end else begin
            state_d     = FULL;
            rsp_valid_d = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, round-robin pointer and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(NREQ - 1);
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = gnt_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule : add_arbiter

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter (WIDTH=8, NREQ=4).
module tb_add_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0][7:0] req_a;
  logic [3:0][7:0] req_b;
  logic [3:0]      req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_sum;
  logic            rsp_carry;
  logic            rsp_ready;

  int checks = 0;
  int errors = 0;

  add_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [7:0] s, input logic c);
    chk({tag, ".valid"}, rsp_valid, v);
    chk({tag, ".id"},    rsp_id,    id);
    chk({tag, ".sum"},   rsp_sum,   s);
    chk({tag, ".carry"}, rsp_carry, c);
  endtask

  // Response-side protocol: a stalled response must not change across the edge.
  logic       hold_seen = 1'b0;
  logic [1:0] hold_id;
  logic [7:0] hold_sum;
  logic       hold_carry;
  always @(posedge clk) begin
    if (rst_n && hold_seen) begin
      checks++;
      assert ({rsp_valid, rsp_id, rsp_sum, rsp_carry} === {1'b1, hold_id, hold_sum, hold_carry}) else begin
        errors++;
        $error("FAIL rsp_stable observed=%0h expected=%0h",
               {rsp_valid, rsp_id, rsp_sum, rsp_carry}, {1'b1, hold_id, hold_sum, hold_carry});
      end
    end
    hold_seen  <= rst_n && rsp_valid && !rsp_ready;
    hold_id    <= rsp_id;
    hold_sum   <= rsp_sum;
    hold_carry <= rsp_carry;
  end

  initial begin
    logic [1:0] order [6];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2;
    order[3] = 2'd3; order[4] = 2'd0; order[5] = 2'd1;

    // Reset state with a request already pending.
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #3;
    chk_rsp("reset", 1'b0, 2'd0, 8'd0, 1'b0);
    chk("reset.req_ready", req_ready, 4'b0000);
    req_valid = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;

    // Single requester 3+4.
    req_a[0] = 8'd3; req_b[0] = 8'd4; req_valid = 4'b0001;
    #1 chk("single.req_ready", req_ready, 4'b0001);
    tick();
    chk_rsp("single", 1'b1, 2'd0, 8'd7, 1'b0);

    // Overflow cases, back-to-back on the same requester.
    req_a[0] = 8'd200; req_b[0] = 8'd100;
    #1 chk("ovf1.req_ready", req_ready, 4'b0001);
    tick();
    chk_rsp("ovf1", 1'b1, 2'd0, 8'd44, 1'b1);
    req_a[0] = 8'd255; req_b[0] = 8'd1;
    tick();
    chk_rsp("ovf2", 1'b1, 2'd0, 8'd0, 1'b1);

    // Move the pointer to 3 so a full round starts at requester 0.
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 8'(10 + i);
      req_b[i] = 8'(20 + i);
    end
    req_valid = 4'b1000;
    #1 chk("pre.req_ready", req_ready, 4'b1000);
    tick();
    chk_rsp("pre", 1'b1, 2'd3, 8'd36, 1'b0);

    // All four continuously valid: 0,1,2,3,0,1 with no gaps.
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("rr%0d.req_ready", k), req_ready, 4'b0001 << order[k]);
      tick();
      chk_rsp($sformatf("rr%0d", k), 1'b1, order[k], 8'(30 + 2 * order[k]), 1'b0);
    end

    // Drain, then load a result from requester 0 (5+6).
    req_valid = 4'b0000;
    tick();
    chk("drain.valid", rsp_valid, 1'b0);
    req_a[0] = 8'd5; req_b[0] = 8'd6; req_valid = 4'b0001;
    tick();
    chk_rsp("bp.load", 1'b1, 2'd0, 8'd11, 1'b0);

    // Backpressure for 3 cycles with req1 and req2 pending.
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d.req_ready", k), req_ready, 4'b0000);
      tick();
      chk_rsp($sformatf("bp%0d", k), 1'b1, 2'd0, 8'd11, 1'b0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp.release.req_ready", req_ready, 4'b0010);
    tick();
    chk_rsp("bp.release", 1'b1, 2'd1, 8'd32, 1'b0);
    req_valid = 4'b0100;
    #1 chk("bp.req2.req_ready", req_ready, 4'b0100);
    tick();
    chk_rsp("bp.req2", 1'b1, 2'd2, 8'd34, 1'b0);

    // Idle after a grant to 2: data holds, then req3 wins over req0.
    req_valid = 4'b0000;
    tick();
    chk_rsp("idle", 1'b0, 2'd2, 8'd34, 1'b0);
    tick();
    req_valid = 4'b1001;
    #1 chk("fair.req_ready", req_ready, 4'b1000);
    tick();
    chk_rsp("fair.r3", 1'b1, 2'd3, 8'd36, 1'b0);
    req_valid = 4'b0001;
    #1 chk("fair2.req_ready", req_ready, 4'b0001);
    tick();
    chk_rsp("fair.r0", 1'b1, 2'd0, 8'd11, 1'b0);

    // Asynchronous reset while FULL with requests valid.
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_rsp("arst", 1'b0, 2'd0, 8'd0, 1'b0);
    chk("arst.req_ready", req_ready, 4'b0000);
    tick();
    chk("arst.hold.req_ready", req_ready, 4'b0000);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1 chk("post.req_ready", req_ready, 4'b0001);
    tick();
    chk_rsp("post", 1'b1, 2'd0, 8'd11, 1'b0);
    req_valid = 4'b0010;
    #1 chk("post2.req_ready", req_ready, 4'b0010);
    tick();
    chk_rsp("post2", 1'b1, 2'd1, 8'd32, 1'b0);
    req_valid = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_add_arbiter
